// File: rtl/router_pkg.sv
// router_pkg: shared router types, port indices and the XY route helper
//   M            number of router ports (request vector width)
//   flit_t       {dest_x, dest_y, payload} single-flit packet
//   ic_state_t   input-unit head-flit FSM states
//   xy_route()   one-hot output port for a destination, X first then Y
package router_pkg;
   localparam int M = 5;
   localparam int COORD_W = 4;
   localparam int PAYLOAD_W = 8;
   localparam int PORT_LOCAL = 0;
   localparam int PORT_NORTH = 1;
   localparam int PORT_EAST = 2;
   localparam int PORT_SOUTH = 3;
   localparam int PORT_WEST = 4;
   typedef struct packed {
      logic [COORD_W-1:0] dest_x;
      logic [COORD_W-1:0] dest_y;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;
   typedef enum logic [1:0] {IDLE, ROUTE, REQ} ic_state_t;
   function automatic logic [0:M-1] xy_route(input logic [COORD_W-1:0] dx, dy, x, y);
      logic [0:M-1] r;
      r = '0;
      if (dx > x) r[PORT_EAST] = 1'b1;
      else if (dx < x) r[PORT_WEST] = 1'b1;
      else if (dy > y) r[PORT_SOUTH] = 1'b1;
      else if (dy < y) r[PORT_NORTH] = 1'b1;
      else r[PORT_LOCAL] = 1'b1;
      return r;
   endfunction
endpackage

// File: rtl/input_fifo.sv
// input_fifo: DEPTH-entry flit FIFO with caller-qualified push/pop
//   clk, reset   clock, synchronous active-high reset
//   push, pop    write/read strobes, already qualified by the caller
//   din          flit written on push
//   head         oldest flit, zero when empty
//   head_next    entry behind the head (ROUTE_LOOKAHEAD_EN builds only)
//   full, empty  occupancy flags
//   count        occupancy, 0..DEPTH
module input_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  flit_t din,
   output flit_t head,
`ifdef ROUTE_LOOKAHEAD_EN
   output flit_t head_next,
`endif
   output logic full,
   output logic empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   flit_t mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign head = empty ? '0 : mem[rd_ptr];
`ifdef ROUTE_LOOKAHEAD_EN
   assign head_next = mem[rd_ptr + AW'(1)];
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/router_input_unit.sv
// router_input_unit: mesh router input port - buffers flits, XY-routes the head, requests and pops on grant
//   clk, reset       clock, synchronous active-high reset (overrides ce)
//   ce               clock enable, low freezes all state
//   i_data/_val      incoming flit and its valid
//   o_en             upstream may send (FIFO not full)
//   o_output_req     one-hot output port request for the head flit, only in REQ
//   i_input_grant    grant for this input; pops the head when in REQ
//   o_data           FIFO head flit
//   o_overflow       sticky: a flit was dropped because the FIFO was full
// Build option ROUTE_LOOKAHEAD_EN: on a grant with more flits queued the request moves
// straight to the next flit's route, skipping the ROUTE bubble.
module router_input_unit
   import router_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int X_LOC = 0,
   parameter int Y_LOC = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   input  flit_t i_data,
   input  logic i_data_val,
   output logic o_en,
   output logic [0:M-1] o_output_req,
   input  logic i_input_grant,
   output flit_t o_data,
   output logic o_overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [COORD_W-1:0] XC = COORD_W'(X_LOC);
   localparam logic [COORD_W-1:0] YC = COORD_W'(Y_LOC);
   ic_state_t state;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic remain;
   logic [AW:0] count;
   assign o_en = !full;
   assign pop = ce && state == REQ && i_input_grant;
   assign push = ce && i_data_val && (!full || pop);
   // a flit is left after this pop, counting one pushed in the same cycle
   assign remain = count > (AW+1)'(1) || push;
`ifdef ROUTE_LOOKAHEAD_EN
   flit_t head_next;
   flit_t follow;
   // with a single entry the follower can only be the flit arriving now
   assign follow = count > (AW+1)'(1) ? head_next : i_data;
`endif
   input_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .din(i_data),
      .head(o_data),
`ifdef ROUTE_LOOKAHEAD_EN
      .head_next(head_next),
`endif
      .full(full),
      .empty(empty),
      .count(count)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         o_output_req <= '0;
         o_overflow <= 1'b0;
      end else if (ce) begin
         if (i_data_val && full && !pop) o_overflow <= 1'b1;
         case (state)
            IDLE: if (!empty || push) state <= ROUTE;
            ROUTE: begin
               o_output_req <= xy_route(o_data.dest_x, o_data.dest_y, XC, YC);
               state <= REQ;
            end
            REQ: if (i_input_grant) begin
`ifdef ROUTE_LOOKAHEAD_EN
               o_output_req <= remain ? xy_route(follow.dest_x, follow.dest_y, XC, YC) : '0;
               state <= remain ? REQ : IDLE;
`else
               o_output_req <= '0;
               state <= remain ? ROUTE : IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_router_input_unit.sv
// tb_router_input_unit: directed and random checks of router_input_unit against a queue model
module tb_router_input_unit;
   import router_pkg::*;
   localparam int DEPTH = 4;
   localparam int XL = 1;
   localparam int YL = 1;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ce = 1'b1;
   logic i_data_val = 1'b0;
   logic i_input_grant = 1'b0;
   flit_t i_data = '0;
   logic o_en;
   logic o_overflow;
   logic [0:M-1] o_output_req;
   flit_t o_data;
   int passed = 0;
   int total = 0;
   flit_t q[$];
   bit showing = 0;
   int pend = 0;
   bit ovf = 0;
   bit live = 0;

   always #5 clk = ~clk;

   router_input_unit #(.DEPTH(DEPTH), .X_LOC(XL), .Y_LOC(YL)) dut (
      .clk(clk),
      .reset(reset),
      .ce(ce),
      .i_data(i_data),
      .i_data_val(i_data_val),
      .o_en(o_en),
      .o_output_req(o_output_req),
      .i_input_grant(i_input_grant),
      .o_data(o_data),
      .o_overflow(o_overflow)
   );

   function automatic logic [0:M-1] exp_route(input flit_t f);
      int p;
      if (int'(f.dest_x) != XL) p = int'(f.dest_x) > XL ? 2 : 4;
      else if (int'(f.dest_y) != YL) p = int'(f.dest_y) > YL ? 3 : 1;
      else p = 0;
      return 5'b10000 >> p;
   endfunction

   function automatic flit_t mk(input int x, input int y);
      flit_t f;
      f.dest_x = COORD_W'(x);
      f.dest_y = COORD_W'(y);
      f.payload = PAYLOAD_W'($urandom);
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   task automatic cyc(input bit v, input flit_t d, input bit g, input bit c);
      i_data_val = v;
      i_data = d;
      i_input_grant = g;
      ce = c;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (o_output_req == '0 && n < 10) begin
         cyc(0, '0, 0, 1);
         n++;
      end
      check("wait_req_timeout", 32'(n < 10), 1);
   endtask

   // Model: queue of buffered flits; 'showing' means the head is being requested,
   // 'pend' counts edges until it will be.
   always @(posedge clk) begin
      bit g;
      bit pushed;
      bit idle;
      if (reset) begin
         q.delete();
         showing = 0;
         pend = 0;
         ovf = 0;
         live = 1;
      end else if (ce) begin
         g = showing && i_input_grant;
         pushed = i_data_val && (q.size() < DEPTH || g);
         if (i_data_val && !pushed) ovf = 1;
         if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) showing = 1;
         end
         idle = q.size() == 0;
         if (g) void'(q.pop_front());
         if (pushed) q.push_back(i_data);
         if (g) begin
            showing = 0;
            if (q.size() > 0) begin
`ifdef ROUTE_LOOKAHEAD_EN
               showing = 1;
`else
               pend = 1;
`endif
            end
         end else if (idle && pushed) pend = 1;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         check("o_en", 32'(o_en), 32'(q.size() < DEPTH));
         check("o_overflow", 32'(o_overflow), 32'(ovf));
         check("o_output_req", 32'(o_output_req), showing ? 32'(exp_route(q[0])) : 32'd0);
         if (showing) check("o_data", 32'(o_data), 32'(q[0]));
      end
   end

   initial begin
      flit_t fl[4];
      logic [0:M-1] exp3[4];
      logic [0:M-1] got3[$];
      logic [0:M-1] v6[$];
      logic [0:M-1] r;
      int pos[$];
      reset = 1;
      cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 1);
      reset = 0;
      check("reset_o_en", 32'(o_en), 1);
      check("reset_req", 32'(o_output_req), 0);
      check("reset_ovf", 32'(o_overflow), 0);
      check("reset_data", 32'(o_data), 0);

      // single flit east: request two cycles after the push, drop after the grant
      cyc(1, mk(3, 0), 0, 1);
      check("t2_route_cycle_req", 32'(o_output_req), 0);
      cyc(0, '0, 0, 1);
      check("t2_req_east", 32'(o_output_req), 32'(5'b00100));
      cyc(0, '0, 0, 1);
      check("t2_req_held", 32'(o_output_req), 32'(5'b00100));
      cyc(0, '0, 1, 1);
      check("t2_req_cleared", 32'(o_output_req), 0);

      // four flits, grant held: requests in push order
      fl[0] = mk(1, 0); fl[1] = mk(1, 2); fl[2] = mk(1, 1); fl[3] = mk(0, 1);
      exp3[0] = 5'b01000; exp3[1] = 5'b00010; exp3[2] = 5'b10000; exp3[3] = 5'b00001;
      for (int i = 0; i < 16; i++) begin
         cyc(i < 4, i < 4 ? fl[i] : '0, 1, 1);
         if (o_output_req != '0) got3.push_back(o_output_req);
      end
      check("t3_req_count", 32'(got3.size()), 4);
      for (int i = 0; i < got3.size() && i < 4; i++) check("t3_req_order", 32'(got3[i]), 32'(exp3[i]));
      check("t3_no_overflow", 32'(o_overflow), 0);

      // fill, overflow, then push while full with a grant
      for (int i = 0; i < 4; i++) cyc(1, mk(2, i), 0, 1);
      check("t4_full_o_en", 32'(o_en), 0);
      cyc(1, mk(0, 0), 0, 1);
      check("t4_overflow", 32'(o_overflow), 1);
      check("t4_req_up", 32'(o_output_req), 32'(5'b00100));
      cyc(1, mk(1, 3), 1, 1);
      check("t4_push_pop_full", 32'(o_en), 0);
      for (int i = 0; i < 12; i++) cyc(0, '0, 1, 1);
      check("t4_drained_o_en", 32'(o_en), 1);
      check("t4_drained_req", 32'(o_output_req), 0);

      // reset while requesting with two flits queued
      cyc(1, mk(2, 2), 0, 1);
      cyc(1, mk(0, 0), 0, 1);
      wait_req();
      reset = 1;
      cyc(0, '0, 1, 1);
      reset = 0;
      check("t1_req", 32'(o_output_req), 0);
      check("t1_o_en", 32'(o_en), 1);
      check("t1_ovf", 32'(o_overflow), 0);
      cyc(0, '0, 0, 1);
      check("t1_stays_empty", 32'(o_output_req), 0);

      // ce low during REQ with grant and a push attempt: nothing moves
      cyc(1, mk(1, 0), 0, 1);
      wait_req();
      r = o_output_req;
      for (int i = 0; i < 3; i++) begin
         cyc(1, mk(3, 3), 1, 0);
         check("t5_req_frozen", 32'(o_output_req), 32'(r));
         check("t5_o_en_frozen", 32'(o_en), 1);
      end
      cyc(0, '0, 1, 1);
      check("t5_resumed_pop", 32'(o_output_req), 0);
      for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1);

      // three queued flits, grant held: request spacing
      cyc(1, mk(2, 1), 0, 1);
      cyc(1, mk(0, 1), 0, 1);
      cyc(1, mk(1, 2), 0, 1);
      wait_req();
      for (int i = 0; i < 8; i++) begin
         if (o_output_req != '0) begin
            pos.push_back(i);
            v6.push_back(o_output_req);
         end
         cyc(0, '0, 1, 1);
      end
      check("t6_req_count", 32'(pos.size()), 3);
      exp3[0] = 5'b00100; exp3[1] = 5'b00001; exp3[2] = 5'b00010;
      for (int i = 0; i < pos.size() && i < 3; i++) begin
`ifdef ROUTE_LOOKAHEAD_EN
         check("t6_req_cycle", 32'(pos[i]), 32'(i));
`else
         check("t6_req_cycle", 32'(pos[i]), 32'(2 * i));
`endif
         check("t6_req_value", 32'(v6[i]), 32'(exp3[i]));
      end

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset = $urandom_range(199) == 0;
         cyc(1'($urandom_range(1)), mk($urandom_range(3), $urandom_range(3)),
             1'($urandom_range(1)), $urandom_range(9) != 0);
      end
      reset = 0;
      cyc(0, '0, 0, 1);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
